tinker_alu_issue: RTL
=====================

Name: tinker_alu_issue

Overview:
- Decode/operand-fetch stage that feeds the 64-bit ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes opcode, rd, rs, rt and L.
- Reads the 32x64 register file and issues {opcode, param1, param2, rd} to the ALU with a valid/ready handshake.
- Consumes ALU results on a writeback port; a per-register busy scoreboard blocks RAW/WAW hazards.

Parameters:
- NREGS, 32, number of architectural registers; register index width is 5.
- STACK_INIT, 64'h80000, reset value of r31; all other registers reset to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_instr  in  32  instruction: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], L[11:0].
- in_ready  out  1  stage can accept an instruction.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  ALU/downstream accepts operands.
- out_opcode  out  5  opcode to ALU.
- out_param1  out  64  first ALU operand.
- out_param2  out  64  second ALU operand.
- out_rd  out  5  destination register, carried to writeback.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  5  writeback register index.
- wb_data  in  64  ALU result to write.
- illegal_op  out  1  sticky flag: a non-ALU opcode was received.
- stall_cnt  out  32  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, reset=1):
  - State = IDLE; in_ready=1; out_valid=0.
  - out_opcode, out_param1, out_param2, out_rd = 0; illegal_op=0; stall_cnt=0.
  - All busy bits clear; r0..r30 = 0; r31 = STACK_INIT.
  - Reset mid-operation discards any held instruction.
- FSM states: IDLE, CHECK, ISSUE.
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches in_instr and moves to CHECK. in_ready=0 in CHECK and ISSUE.
  - CHECK, illegal opcode: set illegal_op, drop the instruction, go to IDLE. Legal opcodes are 0x00-0x07, 0x11, 0x12, 0x14-0x1d.
  - CHECK, hazard: stay in CHECK and increment stall_cnt, saturating at 32'hFFFFFFFF. A hazard is a busy bit set on any source register or on rd.
  - CHECK, no hazard: load the output registers, set busy[rd], set out_valid=1, go to ISSUE. Earliest out_valid is 1 cycle after the accepting edge.
  - ISSUE: hold all outputs stable while out_valid & !out_ready. When out_ready=1, clear out_valid and go to IDLE.
- Operand selection (L is zero-extended to 64 bits):
  - R-type 0x00,0x01,0x02,0x04,0x06,0x14-0x18,0x1a,0x1c,0x1d: param1=R[rs], param2=R[rt]; sources rs, rt.
  - 0x03 (not) and 0x11 (mov rd,rs): param1=R[rs], param2=0; source rs.
  - Immediate 0x05,0x07,0x12,0x19,0x1b: param1=R[rd], param2=L; source rd.
  - out_opcode is the opcode unchanged; out_rd=rd.
- Writeback:
  - wb_valid=1 writes wb_data into R[wb_rd] and clears busy[wb_rd] at the clock edge.
  - If busy[rd] is set by issue and cleared by wb on the same edge, the set wins.
  - Writeback is accepted in every state, with no backpressure.
  - wb_valid to a register that is not busy still writes; the busy bit is left clear.
- Without bypass, a register written at edge N is first seen by the CHECK hazard test in the cycle after edge N.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: in CHECK, a busy source or rd that matches wb_rd with wb_valid=1 in the same cycle counts as ready. wb_data is muxed into the operand, so the issue happens on that same edge.
- Undefined: no forwarding; the instruction stalls until the cycle after writeback. This costs exactly 1 extra stall cycle versus the bypass build.

Test Plan:
- Reset then send add (0x18) rd=3, rs=31, rt=0 -> out_param1=64'h80000, out_param2=0, out_rd=3, out_valid 1 cycle after accept; busy[3]=1.
- addi (0x19) rd=5, L=12'hFFF with R5=10 -> out_param1=10, out_param2=64'hFFF.
- add r3 issued, then sub (0x1a) rd=4, rs=3 with no wb -> stays in CHECK, stall_cnt increments each cycle. wb_valid rd=3 data=7 -> issues with param1=7. Stall count after wb is 1 fewer with WB_BYPASS_EN.
- out_ready held 0 for 5 cycles in ISSUE -> outputs stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Opcode 0x0b -> illegal_op=1 and stays 1; no out_valid; the next legal instruction issues normally.
- Assert reset while in CHECK with busy[3]=1 -> out_valid=0, busy clear, r31=64'h80000, stall_cnt=0.

Source files
------------

// File: rtl/tinker_alu_issue.sv
// Decode/operand-fetch stage in front of the 64-bit tinker ALU, with a busy scoreboard.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the operand read.
module tinker_alu_issue #(
    parameter int          NREGS      = 32,
    parameter logic [63:0] STACK_INIT = 64'h80000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_opcode,
    output logic [63:0] out_param1,
    output logic [63:0] out_param2,
    output logic [4:0]  out_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        illegal_op,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    localparam logic [1:0] CLS_ILL = 2'd0;
    localparam logic [1:0] CLS_R   = 2'd1;
    localparam logic [1:0] CLS_U   = 2'd2;
    localparam logic [1:0] CLS_I   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [63:0]      regs_q [NREGS];
    logic [63:0]      regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_opcode_q, out_opcode_d;
    logic [63:0]      out_param1_q, out_param1_d;
    logic [63:0]      out_param2_q, out_param2_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             illegal_q, illegal_d;
    logic [31:0]      stall_q, stall_d;

    logic [4:0]  op, rd, rs, rt, src_a;
    logic [11:0] lit;
    logic [1:0]  cls;
    logic        hazard;
    logic [63:0] p1, p2;

    // A busy register stops being a hazard when its writeback lands this cycle (bypass build only).
    function automatic logic blocked(input logic [4:0] r);
`ifdef WB_BYPASS_EN
        return busy_q[r] && !(wb_valid && wb_rd == r);
`else
        return busy_q[r];
`endif
    endfunction

    function automatic logic [63:0] read_reg(input logic [4:0] r);
`ifdef WB_BYPASS_EN
        return (wb_valid && wb_rd == r) ? wb_data : regs_q[r];
`else
        return regs_q[r];
`endif
    endfunction

    always_comb begin
        op  = instr_q[31:27];
        rd  = instr_q[26:22];
        rs  = instr_q[21:17];
        rt  = instr_q[16:12];
        lit = instr_q[11:0];
        case (op)
            5'h00, 5'h01, 5'h02, 5'h04, 5'h06,
            5'h14, 5'h15, 5'h16, 5'h17, 5'h18,
            5'h1a, 5'h1c, 5'h1d:                 cls = CLS_R;
            5'h03, 5'h11:                        cls = CLS_U;
            5'h05, 5'h07, 5'h12, 5'h19, 5'h1b:   cls = CLS_I;
            default:                             cls = CLS_ILL;
        endcase
        src_a  = (cls == CLS_I) ? rd : rs;
        hazard = blocked(src_a) || blocked(rd) || ((cls == CLS_R) && blocked(rt));
        p1     = read_reg(src_a);
        case (cls)
            CLS_R:   p2 = read_reg(rt);
            CLS_I:   p2 = {52'd0, lit};
            default: p2 = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        busy_d       = busy_q;
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_param1_d = out_param1_q;
        out_param2_d = out_param2_q;
        out_rd_d     = out_rd_q;
        illegal_d    = illegal_q;
        stall_d      = stall_q;

        if (wb_valid) begin
            regs_d[wb_rd] = wb_data;
            busy_d[wb_rd] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cls == CLS_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = IDLE;
                end else if (hazard) begin
                    if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
                end else begin
                    // Set after the writeback clear so an issue on the same edge keeps rd busy.
                    busy_d[rd]   = 1'b1;
                    out_valid_d  = 1'b1;
                    out_opcode_d = op;
                    out_param1_d = p1;
                    out_param2_d = p2;
                    out_rd_d     = rd;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            busy_q       <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_param1_q <= '0;
            out_param2_q <= '0;
            out_rd_q     <= '0;
            illegal_q    <= 1'b0;
            stall_q      <= '0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= (i == NREGS - 1) ? STACK_INIT : 64'd0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_param1_q <= out_param1_d;
            out_param2_q <= out_param2_d;
            out_rd_q     <= out_rd_d;
            illegal_q    <= illegal_d;
            stall_q      <= stall_d;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_opcode = out_opcode_q;
    assign out_param1 = out_param1_q;
    assign out_param2 = out_param2_q;
    assign out_rd     = out_rd_q;
    assign illegal_op = illegal_q;
    assign stall_cnt  = stall_q;

endmodule
